// File: rtl/mac_scheduler_pkg.sv
// ============================================================================
// Module      : mac_scheduler_pkg
// Description : Shared widths, saturation limits and FSM state encoding for
//               the sequential MAC filter controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_scheduler_pkg;

  // Default fixed-point format: sign + ENT integer bits + FRAC fraction bits
  localparam int CANT_BITS_DEF = 25;
  localparam int ENT_DEF       = 10;
  localparam int FRAC_DEF      = 14;
  localparam int TAPS_DEF      = 5;
  localparam int AW_DEF        = 3;

  // Saturation limits for the default word width
  localparam logic [CANT_BITS_DEF-1:0] SAT_MAX_POS = {1'b0, {(CANT_BITS_DEF-1){1'b1}}};
  localparam logic [CANT_BITS_DEF-1:0] SAT_MAX_NEG = {1'b1, {(CANT_BITS_DEF-1){1'b0}}};

  // Controller states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mac_scheduler_sat_add.sv
// ============================================================================
// Module      : mac_scheduler_sat_add
// Description : Combinational two's-complement adder that clamps to the most
//               positive / most negative word on signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_scheduler_sat_add
  import mac_scheduler_pkg::*;
#(
  parameter int W = CANT_BITS_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W-1:0] sum;
  logic         ovf;

  // Overflow only when both operands share a sign the sum does not
  always_comb begin
    sum = a + b;
    ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    y   = sum;
    if (ovf) begin
      y = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_scheduler_sat_trunc.sv
// ============================================================================
// Module      : mac_scheduler_sat_trunc
// Description : Saturating truncation of a full Q(2*ENT.2*FRAC) product back
//               to a Q(ENT.FRAC) word. In-range values are floored toward
//               minus infinity by dropping the low FRAC bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_scheduler_sat_trunc
  import mac_scheduler_pkg::*;
#(
  parameter int W    = CANT_BITS_DEF,
  parameter int ENT  = ENT_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic [2*W-2:0] p,
  output logic [W-1:0]   t
);

  localparam int PW     = 2*W-1;
  localparam int OVF_HI = 2*W-3;
  localparam int OVF_LO = 2*FRAC+ENT;

  logic                     sign;
  logic [OVF_HI-OVF_LO:0]   ovf_bits;
  logic                     unused_frac;

  // Dropped fraction bits only matter for the floor, which truncation gives for free
  assign unused_frac = ^p[FRAC-1:0];

  // Clamp when the discarded integer bits are not a pure sign extension
  always_comb begin
    sign     = p[PW-1];
    ovf_bits = p[OVF_HI:OVF_LO];
    if (!sign && (|ovf_bits)) begin
      t = {1'b0, {(W-1){1'b1}}};
    end else if (sign && !(&ovf_bits)) begin
      t = {1'b1, {(W-1){1'b0}}};
    end else begin
      t = {sign, p[OVF_LO-1:FRAC]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_scheduler.sv
// ============================================================================
// Module      : mac_scheduler
// Description : Sequential multiply-accumulate controller for one FIR output.
//               One multiplier is time-shared across TAPS coefficient/sample
//               pairs; coefficients come from an external async-read ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_scheduler
  import mac_scheduler_pkg::*;
#(
  parameter int CANT_BITS = CANT_BITS_DEF,
  parameter int ENT       = ENT_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int TAPS      = TAPS_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CANT_BITS-1:0] x_in,
  output logic [AW-1:0]        coef_addr,
  input  logic [CANT_BITS-1:0] coef_data,
  output logic                 busy,
  output logic                 done,
  output logic [CANT_BITS-1:0] y_out
);

  localparam int PW = 2*CANT_BITS-1;

  state_e               state;
  state_e               state_nxt;
  logic [CANT_BITS-1:0] x_line [TAPS];
  logic [CANT_BITS-1:0] acc;
  logic [AW-1:0]        idx;
  logic [CANT_BITS-1:0] x_sel;
  logic [PW-1:0]        coef_ext;
  logic [PW-1:0]        x_ext;
  logic [PW-1:0]        prod;
  logic [CANT_BITS-1:0] t;
  logic [CANT_BITS-1:0] acc_sum;
  logic                 accept;
  logic                 step;
  logic                 last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; start is only honoured from IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        step = 1'b1;
        if (idx == AW'(TAPS-1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the delay-line tap paired with the current coefficient
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (idx == AW'(i)) begin
        x_sel = x_line[i];
      end
    end
  end

  // Sign-extend both operands so the low PW bits of the product are exact
  assign coef_ext = {{(PW-CANT_BITS){coef_data[CANT_BITS-1]}}, coef_data};
  assign x_ext    = {{(PW-CANT_BITS){x_sel[CANT_BITS-1]}}, x_sel};
  assign prod     = coef_ext * x_ext;

  mac_scheduler_sat_trunc #(
    .W    (CANT_BITS),
    .ENT  (ENT),
    .FRAC (FRAC)
  ) u_trunc (
    .p (prod),
    .t (t)
  );

  mac_scheduler_sat_add #(
    .W (CANT_BITS)
  ) u_add (
    .a (acc),
    .b (t),
    .y (acc_sum)
  );

  // Delay line, accumulator, tap index and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x_line[i] <= '0;
      end
      acc       <= '0;
      idx       <= '0;
      coef_addr <= '0;
      y_out     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        x_line[0] <= x_in;
        for (int i = 1; i < TAPS; i++) begin
          x_line[i] <= x_line[i-1];
        end
        acc       <= '0;
        idx       <= '0;
        coef_addr <= '0;
      end else if (step) begin
        acc       <= acc_sum;
        idx       <= idx + AW'(1);
        coef_addr <= idx + AW'(1);
        if (last) begin
          y_out     <= acc_sum;
          done      <= 1'b1;
          coef_addr <= '0;
        end
      end
    end
  end

  assign busy = (state == MAC);

endmodule

`default_nettype wire

// File: tb/tb_mac_scheduler.sv
// ============================================================================
// Module      : tb_mac_scheduler
// Description : Self-checking bench for mac_scheduler with a behavioural
//               integer-arithmetic filter model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mac_scheduler;

  localparam int W    = 25;
  localparam int ENT  = 10;
  localparam int FRAC = 14;
  localparam int TAPS = 5;
  localparam int AW   = 3;
  localparam logic [W-1:0] ONE = 25'h0004000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  x_in;
  logic [AW-1:0] coef_addr;
  logic [W-1:0]  coef_data;
  logic          busy;
  logic          done;
  logic [W-1:0]  y_out;

  logic [W-1:0]  coef_rom [1<<AW];
  longint        model_line [TAPS];

  int n_checks = 0;
  int n_fail   = 0;

  assign coef_data = coef_rom[coef_addr];

  always #5 clk = ~clk;

  mac_scheduler #(
    .CANT_BITS (W),
    .ENT       (ENT),
    .FRAC      (FRAC),
    .TAPS      (TAPS),
    .AW        (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy),
    .done      (done),
    .y_out     (y_out)
  );

  // ---------------- reference model ----------------
  function automatic longint to_s(input logic [W-1:0] v);
    longint r;
    r = longint'(v);
    if (v[W-1]) r = r - (longint'(1) << W);
    return r;
  endfunction

  function automatic logic [W-1:0] to_u(input longint v);
    logic [63:0] b;
    b = v;
    return b[W-1:0];
  endfunction

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (W-1)) - 1;
    lo = -(longint'(1) << (W-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // y = sum over k of sat(floor(c[k]*x[k] / 2^FRAC)), saturating after each add
  function automatic logic [W-1:0] model_y();
    longint acc, p;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      p   = to_s(coef_rom[k]) * model_line[k];
      acc = clamp(acc + clamp(p >>> FRAC));
    end
    return to_u(acc);
  endfunction

  function automatic logic [W-1:0] rand_word();
    longint s;
    s = longint'($urandom_range(0, 33554430)) - 64'sd16777215;
    s = s >>> $urandom_range(0, 12);
    return to_u(s);
  endfunction

  // Drive one start, update the model, wait (bounded) for done.
  // lat = cycles from the accepting edge to done, 0 on timeout.
  task automatic issue_start(input logic [W-1:0] x, output int lat,
                             output logic [W-1:0] exp_y,
                             output logic busy0, output logic done0);
    @(negedge clk);
    start = 1'b1;
    x_in  = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy0 = busy;
    done0 = done;
    for (int i = TAPS-1; i > 0; i--) model_line[i] = model_line[i-1];
    model_line[0] = to_s(x);
    exp_y = model_y();
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < TAPS; i++) model_line[i] = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    for (int i = 0; i < (1<<AW); i++) coef_rom[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (y_out !== '0) begin n_fail++; $display("FAIL reset_y: got %h want 0", y_out); end
    n_checks++; if (coef_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", coef_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_unity();
    int lat;
    logic [W-1:0] exp_y;
    logic b0, d0;
    for (int i = 0; i < (1<<AW); i++) coef_rom[i] = ONE;
    for (int n = 1; n <= TAPS; n++) begin
      issue_start(ONE, lat, exp_y, b0, d0);
      n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL unity_busy[%0d]: got %b want 1", n, b0); end
      n_checks++; if (lat != TAPS) begin n_fail++; $display("FAIL unity_latency[%0d]: got %0d want %0d", n, lat, TAPS); end
      n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL unity_y[%0d]: got %h want %h", n, y_out, exp_y); end
    end
    n_checks++; if (y_out !== 25'h0014000) begin n_fail++; $display("FAIL unity_final: got %h want 0014000", y_out); end
    n_checks++; if (coef_addr !== '0) begin n_fail++; $display("FAIL unity_addr_done: got %h want 0", coef_addr); end
  endtask

  task automatic test_single_tap();
    logic [W-1:0] xs [4];
    logic [W-1:0] cs [4];
    logic [W-1:0] ys [4];
    int lat;
    logic [W-1:0] exp_y;
    logic b0, d0;
    xs[0] = 25'h1FFC000; cs[0] = ONE;         ys[0] = 25'h1FFC000;
    xs[1] = 25'h0000001; cs[1] = 25'h0002000; ys[1] = 25'h0000000;
    xs[2] = 25'h1FFFFFF; cs[2] = 25'h0002000; ys[2] = 25'h1FFFFFF;
    xs[3] = 25'h0190000; cs[3] = 25'h0050000; ys[3] = 25'h0FFFFFF;
    for (int i = 0; i < (1<<AW); i++) coef_rom[i] = '0;
    for (int v = 0; v < 4; v++) begin
      coef_rom[0] = cs[v];
      issue_start(xs[v], lat, exp_y, b0, d0);
      n_checks++; if (lat != TAPS) begin n_fail++; $display("FAIL tap0_latency[%0d]: got %0d want %0d", v, lat, TAPS); end
      n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL tap0_model[%0d]: got %h want %h", v, y_out, exp_y); end
      n_checks++; if (y_out !== ys[v]) begin n_fail++; $display("FAIL tap0_vector[%0d]: got %h want %h", v, y_out, ys[v]); end
    end
  endtask

  task automatic test_acc_overflow();
    int lat;
    logic [W-1:0] exp_y;
    logic b0, d0;
    logic [W-1:0] pos, neg;
    pos = to_u(64'sd9830400);
    neg = to_u(-64'sd9830400);
    for (int i = 0; i < (1<<AW); i++) coef_rom[i] = ONE;
    for (int n = 0; n < TAPS; n++) issue_start(pos, lat, exp_y, b0, d0);
    n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL acc_pos_model: got %h want %h", y_out, exp_y); end
    n_checks++; if (y_out !== 25'h0FFFFFF) begin n_fail++; $display("FAIL acc_pos_sat: got %h want 0FFFFFF", y_out); end
    for (int n = 0; n < TAPS; n++) issue_start(neg, lat, exp_y, b0, d0);
    n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL acc_neg_model: got %h want %h", y_out, exp_y); end
    n_checks++; if (y_out !== 25'h1000000) begin n_fail++; $display("FAIL acc_neg_sat: got %h want 1000000", y_out); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [W-1:0] exp_y;
    logic b0, d0;
    for (int k = 0; k < (1<<AW); k++) coef_rom[k] = to_u(longint'(k+1) * 64'sd4096);
    // accepted sample
    @(negedge clk);
    start = 1'b1;
    x_in  = rand_word();
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = TAPS-1; i > 0; i--) model_line[i] = model_line[i-1];
    model_line[0] = to_s(x_in);
    exp_y = model_y();
    // request while busy must be dropped
    @(negedge clk);
    start = 1'b1;
    x_in  = to_u(64'sd123456);
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b want 1", busy); end
    lat = 0;
    for (int c = 2; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat != TAPS) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat, TAPS); end
    n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL ignore_y: got %h want %h", y_out, exp_y); end
    // a following sample exposes any shift caused by the dropped request
    issue_start(rand_word(), lat, exp_y, b0, d0);
    n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL ignore_line: got %h want %h", y_out, exp_y); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] exp_y;
    logic b0, d0;
    time t_prev;
    for (int k = 0; k < TAPS; k++) coef_rom[k] = rand_word();
    issue_start(rand_word(), lat, exp_y, b0, d0);
    t_prev = $time;
    for (int n = 0; n < 3; n++) begin
      issue_start(rand_word(), lat, exp_y, b0, d0);
      n_checks++; if (d0 !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse[%0d]: done got %b want 0", n, d0); end
      n_checks++; if (($time - t_prev) != 60) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0t want 60", n, $time - t_prev); end
      n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL b2b_y[%0d]: got %h want %h", n, y_out, exp_y); end
      t_prev = $time;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [W-1:0] exp_y;
    logic b0, d0;
    logic saw_done;
    for (int i = 0; i < (1<<AW); i++) coef_rom[i] = ONE;
    @(negedge clk);
    start = 1'b1;
    x_in  = ONE;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (coef_addr !== 3'd2) begin n_fail++; $display("FAIL mid_addr: got %0d want 2", coef_addr); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", done); end
    n_checks++; if (y_out !== '0) begin n_fail++; $display("FAIL mid_y: got %h want 0", y_out); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_abort: done got %b want 0", saw_done); end
    issue_start(ONE, lat, exp_y, b0, d0);
    n_checks++; if (lat != TAPS) begin n_fail++; $display("FAIL mid_latency: got %0d want %0d", lat, TAPS); end
    n_checks++; if (y_out !== ONE) begin n_fail++; $display("FAIL mid_restart: got %h want %h", y_out, ONE); end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] exp_y;
    logic b0, d0;
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < TAPS; k++) coef_rom[k] = rand_word();
      issue_start(rand_word(), lat, exp_y, b0, d0);
      n_checks++; if (lat != TAPS) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, TAPS); end
      n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL rand_y[%0d]: got %h want %h", n, y_out, exp_y); end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_single_tap();
    test_acc_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
